imm_gen_stage: RTL and testbench
================================

Name: imm_gen_stage

Overview:
- Registered, parametrised immediate-generation stage between fetch and decode.
- Accepts a raw 32-bit RISC-V instruction with a valid/ready handshake and classifies the immediate format from the opcode itself, so no external control is needed.
- Emits the XLEN-wide extended immediate, its type code, the instruction and a sideband tag.
- Contains a 2-entry skid buffer, so the input side sees full throughput under backpressure.

Parameters:
- XLEN, 32, datapath width; legal values 32 or 64.
- TAG_W, 32, width of the sideband tag carried alongside the instruction (typically the PC).

Ports:
- clk  in  1  single clock; all state is rising-edge.
- rstN  in  1  asynchronous active-low reset.
- flush  in  1  synchronous kill of all buffered entries.
- inValid  in  1  input instruction valid.
- inReady  out  1  stage can accept an instruction this cycle.
- inInstr  in  32  raw instruction word.
- inTag  in  TAG_W  sideband tag.
- outValid  out  1  output entry valid.
- outReady  in  1  consumer accepts this cycle.
- outInstr  out  32  instruction of the head entry.
- outTag  out  TAG_W  tag of the head entry.
- outImm  out  XLEN  extended immediate.
- outImmType  out  3  immediate type code (see package).

Behaviour:
- Reset (rstN=0, asynchronous): entry count=0, outValid=0, outImm=0, outInstr=0, outTag=0, outImmType=NONE; inReady=1.
- Type decode from inInstr[6:0]:
  - 0010011 OP-IMM with funct3 001 or 101 -> SHAMT; all other OP-IMM -> I.
  - 0000011 load and 1100111 JALR -> I.
  - 0100011 -> S; 1100011 -> B; 0110111 LUI and 0010111 AUIPC -> U; 1101111 -> J.
  - 0011011 OP-IMM-32 when XLEN=64: shifts -> SHAMT with 5-bit shamt, others -> I; when XLEN=32 this opcode -> NONE.
  - 1110011 SYSTEM -> I (see optional feature).
  - Anything else -> NONE with imm=0.
- Immediate formation (RISC-V standard):
  - SHAMT: zero-extended instr[24:20] for XLEN=32; instr[25:20] for XLEN=64 except OP-IMM-32, which uses instr[24:20].
  - I: sext(instr[31:20]).
  - S: sext({instr[31:25],instr[11:7]}).
  - B: sext({instr[31],instr[7],instr[30:25],instr[11:8],1'b0}).
  - U: sext({instr[31:12],12'b0}); sign-extension applies to XLEN=64.
  - J: sext({instr[31],instr[19:12],instr[20],instr[30:21],1'b0}).
  - All sign-extension is from instr[31] to XLEN.
- Buffering and handshake:
  - Decode happens on the input side; the stored entry is {instr, tag, imm, type}. Latency is 1 cycle from accept to outValid.
  - Accept when inValid&&inReady; pop when outValid&&outReady.
  - inReady = (count<2), derived from registered state only, never combinationally from outReady.
  - Strict FIFO order; the output always presents the head entry.
  - Simultaneous push and pop: count unchanged and both take effect.
  - Push at count=2 is impossible because inReady=0.
  - Output fields are stable while outValid&&!outReady.
- flush: the next edge sets count=0 and outValid=0, and a concurrent push is discarded. flush has priority over push and pop.
- Reset mid-operation discards all entries immediately.
- Output fields when outValid=0 are don't-care but deterministic: they hold the last value.

Optional Feature:
- Macro IMM_GEN_CSR_IMM_EN.
- Defined: SYSTEM with funct3[2]=1 (CSRRWI, CSRRSI, CSRRCI) -> type Z=111, imm = zero-extended instr[19:15]; SYSTEM with funct3[2]=0 stays I.
- Undefined: all SYSTEM instructions -> I, and code 111 is never produced.

Decomposition:
- Package imm_gen_pkg holds:
  - typedef imm_type_e (3 bits): NONE=000, SHAMT=001, I=010, S=011, B=100, U=101, J=110, Z=111.
  - Opcode localparams.
  - Typedef of the packed buffer-entry struct.
- Sub-module imm_decode: purely combinational, parametrised by XLEN, mapping instr to {type, imm}.
- imm_gen_stage itself owns only the skid buffer, the handshake and the flush logic.

Test Plan:
- XLEN=32: push 0xFFF00093 (addi x1,x0,-1) with outReady=1 -> the next cycle shows outValid=1, outImm=0xFFFFFFFF, outImmType=I.
- Push 0xFE000EE3 (beq x0,x0,-4) -> outImm=0xFFFFFFFC, type B. Push 0x123450B7 (lui) -> outImm=0x12345000, type U.
- XLEN=64:
  - 0x800000B7 -> outImm=0xFFFFFFFF80000000, type U.
  - slli x1,x1,63 (0x03F09093) -> outImm=63, type SHAMT.
- Backpressure: hold outReady=0 and offer 3 back-to-back instructions -> two are accepted and inReady=0 from the cycle after the second accept. Then set outReady=1 -> entries emerge in order with no loss or duplication, and the third is accepted once inReady returns to 1.
- Flush with count=2 while pushing -> next cycle outValid=0, inReady=1, and none of the three instructions ever appear. Separately, assert rstN low asynchronously mid-stream -> outValid drops immediately, with no clock edge needed.
- Push 0x300FD073 (csrrwi): with IMM_GEN_CSR_IMM_EN -> outImm=0x1F, type Z; without it -> outImm=0x300, type I.

Source files
------------

// File: rtl/imm_gen_pkg.sv
// rtl/imm_gen_pkg.sv - immediate type codes, opcodes and buffer-entry type for imm_gen_stage
package imm_gen_pkg;

  typedef enum logic [2:0] {
    IMM_NONE  = 3'b000,
    IMM_SHAMT = 3'b001,
    IMM_I     = 3'b010,
    IMM_S     = 3'b011,
    IMM_B     = 3'b100,
    IMM_U     = 3'b101,
    IMM_J     = 3'b110,
    IMM_Z     = 3'b111
  } imm_type_e;

  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

  // Width-independent part of a buffered entry; imm and tag ride alongside at XLEN/TAG_W.
  typedef struct packed {
    logic [31:0] instr;
    imm_type_e   itype;
  } imm_entry_t;

endpackage

// File: rtl/imm_decode.sv
// rtl/imm_decode.sv - combinational RISC-V immediate classification and extension
// Optional: IMM_GEN_CSR_IMM_EN decodes CSR*I instructions to the Z type.
module imm_decode
  import imm_gen_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  output imm_type_e       itype,
  output logic [XLEN-1:0] imm
);

  logic [2:0] funct3;
  logic       is_shift;

  assign funct3   = instr[14:12];
  assign is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);

  always_comb begin
    itype = IMM_NONE;
    imm   = '0;
    case (instr[6:0])
      OPC_OP_IMM: begin
        if (is_shift) begin
          itype = IMM_SHAMT;
          imm   = (XLEN == 64) ? XLEN'(instr[25:20]) : XLEN'(instr[24:20]);
        end else begin
          itype = IMM_I;
          imm   = XLEN'($signed(instr[31:20]));
        end
      end
      OPC_OP_IMM_32: begin
        // Word-sized ops only exist on RV64; shift amount is always 5 bits here.
        if (XLEN == 64) begin
          if (is_shift) begin
            itype = IMM_SHAMT;
            imm   = XLEN'(instr[24:20]);
          end else begin
            itype = IMM_I;
            imm   = XLEN'($signed(instr[31:20]));
          end
        end
      end
      OPC_LOAD, OPC_JALR: begin
        itype = IMM_I;
        imm   = XLEN'($signed(instr[31:20]));
      end
      OPC_STORE: begin
        itype = IMM_S;
        imm   = XLEN'($signed({instr[31:25], instr[11:7]}));
      end
      OPC_BRANCH: begin
        itype = IMM_B;
        imm   = XLEN'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
      end
      OPC_LUI, OPC_AUIPC: begin
        itype = IMM_U;
        imm   = XLEN'($signed({instr[31:12], 12'b0}));
      end
      OPC_JAL: begin
        itype = IMM_J;
        imm   = XLEN'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));
      end
      OPC_SYSTEM: begin
`ifdef IMM_GEN_CSR_IMM_EN
        if (funct3[2]) begin
          itype = IMM_Z;
          imm   = XLEN'(instr[19:15]);
        end else begin
          itype = IMM_I;
          imm   = XLEN'($signed(instr[31:20]));
        end
`else
        itype = IMM_I;
        imm   = XLEN'($signed(instr[31:20]));
`endif
      end
      default: begin
        itype = IMM_NONE;
        imm   = '0;
      end
    endcase
  end

endmodule

// File: rtl/imm_gen_stage.sv
// rtl/imm_gen_stage.sv - registered immediate-generation stage with a 2-entry skid buffer
// Optional: IMM_GEN_CSR_IMM_EN (handled inside imm_decode).
module imm_gen_stage
  import imm_gen_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32
) (
  input  logic             clk,
  input  logic             rstN,
  input  logic             flush,
  input  logic             inValid,
  output logic             inReady,
  input  logic [31:0]      inInstr,
  input  logic [TAG_W-1:0] inTag,
  output logic             outValid,
  input  logic             outReady,
  output logic [31:0]      outInstr,
  output logic [TAG_W-1:0] outTag,
  output logic [XLEN-1:0]  outImm,
  output imm_type_e        outImmType
);

  logic [1:0]       count;
  imm_type_e        dec_type;
  logic [XLEN-1:0]  dec_imm;
  imm_entry_t       in_e;
  imm_entry_t       head_e,   spill_e;
  logic [XLEN-1:0]  head_imm, spill_imm;
  logic [TAG_W-1:0] head_tag, spill_tag;
  logic             push, pop;
  logic             load_head_in, load_head_spill, load_spill;

  imm_decode #(.XLEN(XLEN)) u_decode (
    .instr (inInstr),
    .itype (dec_type),
    .imm   (dec_imm)
  );

  assign in_e.instr = inInstr;
  assign in_e.itype = dec_type;

  assign inReady  = (count < 2'd2);
  assign outValid = (count != 2'd0);
  assign push     = inValid && inReady;
  assign pop      = outValid && outReady;

  // Head is the output register; the spill slot only fills when head is held.
  assign load_head_in    = push && ((count == 2'd0) || ((count == 2'd1) && pop));
  assign load_head_spill = pop && (count == 2'd2);
  assign load_spill      = push && !pop && (count == 2'd1);

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      count <= 2'd0;
    end else if (flush) begin
      count <= 2'd0;
    end else if (push && !pop) begin
      count <= count + 2'd1;
    end else if (pop && !push) begin
      count <= count - 2'd1;
    end
  end

  // Payload is left untouched on flush so outputs hold their last value.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      head_e    <= '{instr: 32'd0, itype: IMM_NONE};
      head_imm  <= '0;
      head_tag  <= '0;
      spill_e   <= '{instr: 32'd0, itype: IMM_NONE};
      spill_imm <= '0;
      spill_tag <= '0;
    end else if (!flush) begin
      if (load_head_in) begin
        head_e   <= in_e;
        head_imm <= dec_imm;
        head_tag <= inTag;
      end else if (load_head_spill) begin
        head_e   <= spill_e;
        head_imm <= spill_imm;
        head_tag <= spill_tag;
      end
      if (load_spill) begin
        spill_e   <= in_e;
        spill_imm <= dec_imm;
        spill_tag <= inTag;
      end
    end
  end

  assign outInstr   = head_e.instr;
  assign outImmType = head_e.itype;
  assign outImm     = head_imm;
  assign outTag     = head_tag;

endmodule

// File: tb/tb_imm_gen_stage.sv
// tb/tb_imm_gen_stage.sv - scoreboard bench for imm_gen_stage (XLEN=32 and XLEN=64 instances)
module tb_imm_gen_stage;
  import imm_gen_pkg::*;

  localparam int NV = 17;

  typedef struct {
    logic [31:0] instr;
    logic [2:0]  t32;
    logic [31:0] i32;
    logic [2:0]  t64;
    logic [63:0] i64;
  } vec_t;

  typedef struct {
    vec_t        v;
    logic [31:0] tag;
  } exp_t;

  logic        clk = 1'b0;
  logic        rstN = 1'b1;
  logic        flush = 1'b0;
  logic        inValid = 1'b0;
  logic        outReady = 1'b0;
  logic [31:0] inInstr = 32'd0;
  logic [31:0] inTag = 32'd0;

  logic        inReady, outValid;
  logic [31:0] outInstr, outTag, outImm;
  imm_type_e   outImmType;

  logic        inReady64, outValid64;
  logic [31:0] outInstr64, outTag64;
  logic [63:0] outImm64;
  imm_type_e   outImmType64;

  vec_t vecs [NV];
  exp_t sb [$];
  exp_t cur;
  int   seq = 0;
  logic rand_bp = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  imm_gen_stage #(.XLEN(32), .TAG_W(32)) dut32 (
    .clk(clk), .rstN(rstN), .flush(flush),
    .inValid(inValid), .inReady(inReady), .inInstr(inInstr), .inTag(inTag),
    .outValid(outValid), .outReady(outReady), .outInstr(outInstr), .outTag(outTag),
    .outImm(outImm), .outImmType(outImmType)
  );

  imm_gen_stage #(.XLEN(64), .TAG_W(32)) dut64 (
    .clk(clk), .rstN(rstN), .flush(flush),
    .inValid(inValid), .inReady(inReady64), .inInstr(inInstr), .inTag(inTag),
    .outValid(outValid64), .outReady(outReady), .outInstr(outInstr64), .outTag(outTag64),
    .outImm(outImm64), .outImmType(outImmType64)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: push on accept, pop and compare on output handshake.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rstN || flush) begin
      sb.delete();
    end else begin
      if (outValid && outReady) begin
        if (sb.size() == 0) begin
          check_eq($sformatf("spurious_out_%08h", outInstr), 64'd1, 64'd0);
        end else begin
          e = sb.pop_front();
          check_eq($sformatf("instr_%08h", e.v.instr), 64'(outInstr), 64'(e.v.instr));
          check_eq($sformatf("tag_%08h", e.v.instr), 64'(outTag), 64'(e.tag));
          check_eq($sformatf("type32_%08h", e.v.instr), 64'(outImmType), 64'(e.v.t32));
          check_eq($sformatf("imm32_%08h", e.v.instr), 64'(outImm), 64'(e.v.i32));
          check_eq($sformatf("valid64_%08h", e.v.instr), 64'(outValid64), 64'd1);
          check_eq($sformatf("instr64_%08h", e.v.instr), 64'(outInstr64), 64'(e.v.instr));
          check_eq($sformatf("type64_%08h", e.v.instr), 64'(outImmType64), 64'(e.v.t64));
          check_eq($sformatf("imm64_%08h", e.v.instr), outImm64, e.v.i64);
        end
      end
      if (inValid && inReady) sb.push_back(cur);
    end
  end

  task automatic present(input int idx);
    cur.v   = vecs[idx];
    cur.tag = 32'h8000_0000 + 32'(seq * 4);
    seq++;
    inInstr = cur.v.instr;
    inTag   = cur.tag;
    inValid = 1'b1;
  endtask

  task automatic wait_accept();
    logic acc;
    acc = 1'b0;
    for (int c = 0; c < 64 && !acc; c++) begin
      acc = inReady;
      @(posedge clk);
      #1;
      if (rand_bp) outReady = 1'($urandom_range(0, 1));
    end
    inValid = 1'b0;
    check_eq("accept", 64'(acc), 64'd1);
  endtask

  task automatic offer(input int idx);
    present(idx);
    wait_accept();
  endtask

  task automatic drain(input string tag);
    inValid  = 1'b0;
    outReady = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check_eq(tag, 64'(sb.size()), 64'd0);
  endtask

  initial begin
    vecs[0]  = '{32'hFFF00093, IMM_I,     32'hFFFFFFFF, IMM_I,     64'hFFFFFFFF_FFFFFFFF};
    vecs[1]  = '{32'hFE000EE3, IMM_B,     32'hFFFFFFFC, IMM_B,     64'hFFFFFFFF_FFFFFFFC};
    vecs[2]  = '{32'h123450B7, IMM_U,     32'h12345000, IMM_U,     64'h00000000_12345000};
    vecs[3]  = '{32'h800000B7, IMM_U,     32'h80000000, IMM_U,     64'hFFFFFFFF_80000000};
    vecs[4]  = '{32'h03F09093, IMM_SHAMT, 32'h0000001F, IMM_SHAMT, 64'h00000000_0000003F};
    vecs[5]  = '{32'hFE20AC23, IMM_S,     32'hFFFFFFF8, IMM_S,     64'hFFFFFFFF_FFFFFFF8};
    vecs[6]  = '{32'h008000EF, IMM_J,     32'h00000008, IMM_J,     64'h00000000_00000008};
    vecs[7]  = '{32'h00000033, IMM_NONE,  32'h00000000, IMM_NONE,  64'h00000000_00000000};
    vecs[8]  = '{32'hFFF0809B, IMM_NONE,  32'h00000000, IMM_I,     64'hFFFFFFFF_FFFFFFFF};
    vecs[9]  = '{32'h03F0909B, IMM_NONE,  32'h00000000, IMM_SHAMT, 64'h00000000_0000001F};
    vecs[10] = '{32'h4050D093, IMM_SHAMT, 32'h00000005, IMM_SHAMT, 64'h00000000_00000005};
    vecs[11] = '{32'hFFF02083, IMM_I,     32'hFFFFFFFF, IMM_I,     64'hFFFFFFFF_FFFFFFFF};
    vecs[12] = '{32'h000080E7, IMM_I,     32'h00000000, IMM_I,     64'h00000000_00000000};
    vecs[13] = '{32'hFFFFF097, IMM_U,     32'hFFFFF000, IMM_U,     64'hFFFFFFFF_FFFFF000};
`ifdef IMM_GEN_CSR_IMM_EN
    vecs[14] = '{32'h300FD073, IMM_Z,     32'h0000001F, IMM_Z,     64'h00000000_0000001F};
`else
    vecs[14] = '{32'h300FD073, IMM_I,     32'h00000300, IMM_I,     64'h00000000_00000300};
`endif
    vecs[15] = '{32'h30002073, IMM_I,     32'h00000300, IMM_I,     64'h00000000_00000300};
    vecs[16] = '{32'hFFDFF06F, IMM_J,     32'hFFFFFFFC, IMM_J,     64'hFFFFFFFF_FFFFFFFC};

    #1 rstN = 1'b0;
    #2;
    check_eq("rst_out_valid", 64'(outValid), 64'd0);
    check_eq("rst_in_ready", 64'(inReady), 64'd1);
    check_eq("rst_in_ready64", 64'(inReady64), 64'd1);
    check_eq("rst_out_imm", 64'(outImm), 64'd0);
    check_eq("rst_out_imm64", outImm64, 64'd0);
    check_eq("rst_out_instr", 64'(outInstr), 64'd0);
    check_eq("rst_out_tag", 64'(outTag), 64'd0);
    check_eq("rst_out_tag64", 64'(outTag64), 64'd0);
    check_eq("rst_out_type", 64'(outImmType), 64'(IMM_NONE));
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1 rstN = 1'b1;
    @(posedge clk);
    #1;

    // Streaming at full rate
    outReady = 1'b1;
    offer(0);
    check_eq("latency_valid", 64'(outValid), 64'd1);
    for (int i = 1; i < NV; i++) offer(i);
    drain("drain_stream");

    // Backpressure: two accepted, third held off
    outReady = 1'b0;
    offer(1);
    offer(2);
    check_eq("full_in_ready", 64'(inReady), 64'd0);
    present(3);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      check_eq("bp_in_ready", 64'(inReady), 64'd0);
      check_eq("bp_out_valid", 64'(outValid), 64'd1);
      check_eq("bp_hold_instr", 64'(outInstr), 64'(vecs[1].instr));
      check_eq("bp_hold_imm", 64'(outImm), 64'(vecs[1].i32));
    end
    outReady = 1'b1;
    wait_accept();
    drain("drain_backpressure");

    // Flush at count=2 with a pending push, then at count=1 with a real push
    outReady = 1'b0;
    offer(4);
    offer(5);
    present(6);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush   = 1'b0;
    inValid = 1'b0;
    check_eq("flush2_out_valid", 64'(outValid), 64'd0);
    check_eq("flush2_in_ready", 64'(inReady), 64'd1);
    offer(7);
    present(8);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush   = 1'b0;
    inValid = 1'b0;
    check_eq("flush1_out_valid", 64'(outValid), 64'd0);
    outReady = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check_eq("post_flush_idle", 64'(outValid), 64'd0);
    offer(0);
    drain("drain_after_flush");

    // Asynchronous reset mid-stream
    outReady = 1'b0;
    offer(9);
    offer(10);
    #2 rstN = 1'b0;
    #1;
    check_eq("areset_out_valid", 64'(outValid), 64'd0);
    check_eq("areset_in_ready", 64'(inReady), 64'd1);
    check_eq("areset_out_imm", 64'(outImm), 64'd0);
    check_eq("areset_out_instr", 64'(outInstr), 64'd0);
    check_eq("areset_out_valid64", 64'(outValid64), 64'd0);
    @(negedge clk);
    #1 rstN = 1'b1;
    @(posedge clk);
    #1;

    // Random backpressure over the whole table
    rand_bp = 1'b1;
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < NV; i++) offer(i);
    rand_bp = 1'b0;
    drain("drain_random");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got no finish, expected finish before 200000");
    $fatal(1, "watchdog");
  end

endmodule
